range_tracker: RTL and testbench

- Parametrised successor to the single-width range finder used on the chip's io_in/io_out header.
- Captures a burst of samples framed by go/finish and reports, per a mode selected at go, one of: range (max-min), max, min, or sample count.
- Adds unsigned/signed operation, a busy/valid handshake and error classification.
- Instanced inside my_chip, with data and control taken from io_in and results driven to io_out.

---
 rtl/range_tracker.sv | 180 ++++++++++++++++++
 tb/tb_range_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/range_tracker.sv
// rtl/range_tracker.sv - burst range/max/min/count tracker with busy/valid/error handshake
//
// Captures a burst of samples framed by go (first sample) and finish (last
// sample) and reports, according to the mode latched at go, the range
// (max-min), max, min or sample count of the burst. The result is presented
// one cycle after finish and holds until the next accepted go.
//
// Optional build macro: RANGE_TRACKER_MIDPOINT_EN
//   When defined, mode 11 returns the midpoint (max+min)>>>1 instead of the
//   count. The count register is still kept.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   go       in   start of capture, data_in this cycle is the first sample
//   finish   in   end of capture, data_in this cycle is the last sample
//   mode     in   [1:0] 00 range, 01 max, 10 min, 11 count (or midpoint)
//   data_in  in   [WIDTH-1:0] sample bus
//   result   out  [WIDTH:0] selected result, zero/sign extended
//   valid    out  result is stable and valid
//   busy     out  capture in progress
//   error    out  sticky protocol error, cleared by the next accepted go
module range_tracker #(
  parameter int WIDTH     = 9,
  parameter bit SIGNED    = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH:0]   result,
  output logic             valid,
  output logic             busy,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     min_q;
  logic [WIDTH-1:0]     max_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           mode_q;

  logic [WIDTH-1:0]     min_nx;
  logic [WIDTH-1:0]     max_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;

  // Final values of the capture as they will stand after this cycle's sample.
  logic [WIDTH-1:0]     fmin;
  logic [WIDTH-1:0]     fmax;
  logic [CNT_WIDTH-1:0] fcnt;
  logic [1:0]           fmode;
  logic [WIDTH:0]       res_nx;

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return ($signed(a) < $signed(b));
    else        return (a < b);
  endfunction

  // Widen by one bit so that range and midpoint arithmetic cannot overflow.
  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] a);
    return SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
  endfunction

  always_comb begin
    min_nx = less(data_in, min_q) ? data_in : min_q;
    max_nx = less(max_q, data_in) ? data_in : max_q;
    cnt_nx = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  // Outside COLLECT only a go+finish single-sample capture can produce a
  // result, so the final values are the current sample and the live mode.
  always_comb begin
    if (state == COLLECT) begin
      fmin  = min_nx;
      fmax  = max_nx;
      fcnt  = cnt_nx;
      fmode = mode_q;
    end else begin
      fmin  = data_in;
      fmax  = data_in;
      fcnt  = CNT_WIDTH'(1);
      fmode = mode;
    end
  end

`ifdef RANGE_TRACKER_MIDPOINT_EN
  logic [WIDTH:0] mid_sum;
  assign mid_sum = ext(fmax) + ext(fmin);
`endif

  always_comb begin
    res_nx = '0;
    case (fmode)
      2'b00:   res_nx = ext(fmax) - ext(fmin);
      2'b01:   res_nx = ext(fmax);
      2'b10:   res_nx = ext(fmin);
      default: begin
`ifdef RANGE_TRACKER_MIDPOINT_EN
        // Arithmetic shift rounds toward negative infinity in signed mode.
        if (SIGNED) res_nx = $signed(mid_sum) >>> 1;
        else        res_nx = mid_sum >> 1;
`else
        res_nx = (WIDTH+1)'(fcnt);
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      min_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
      mode_q <= '0;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            mode_q <= mode;
            min_q  <= data_in;
            max_q  <= data_in;
            cnt_q  <= CNT_WIDTH'(1);
            error  <= 1'b0;
            if (finish) begin
              state  <= DONE;
              valid  <= 1'b1;
              busy   <= 1'b0;
              result <= res_nx;
            end else begin
              state <= COLLECT;
              valid <= 1'b0;
              busy  <= 1'b1;
            end
          end else if (finish && state == IDLE) begin
            // A stray finish in DONE is harmless; only IDLE flags it.
            error <= 1'b1;
          end
        end
        COLLECT: begin
          if (go) begin
            error  <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            min_q  <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
          end else begin
            min_q <= min_nx;
            max_q <= max_nx;
            cnt_q <= cnt_nx;
            if (finish) begin
              state  <= DONE;
              busy   <= 1'b0;
              valid  <= 1'b1;
              result <= res_nx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_tracker.sv
// tb/tb_range_tracker.sv - self-checking bench for range_tracker
module tb_range_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic       finish;
  logic [1:0] mode;
  logic [8:0] data_in;

  // Instance 0: unsigned, instance 1: signed, instance 2: unsigned with 2-bit counter.
  logic [9:0] res [3];
  logic       val [3];
  logic       bsy [3];
  logic       err [3];

  always #5 clock = ~clock;

  range_tracker #(.WIDTH(9), .SIGNED(1'b0), .CNT_WIDTH(8)) u_uns (
    .clock(clock), .reset(reset), .go(go), .finish(finish), .mode(mode),
    .data_in(data_in), .result(res[0]), .valid(val[0]), .busy(bsy[0]), .error(err[0]));

  range_tracker #(.WIDTH(9), .SIGNED(1'b1), .CNT_WIDTH(8)) u_sgn (
    .clock(clock), .reset(reset), .go(go), .finish(finish), .mode(mode),
    .data_in(data_in), .result(res[1]), .valid(val[1]), .busy(bsy[1]), .error(err[1]));

  range_tracker #(.WIDTH(9), .SIGNED(1'b0), .CNT_WIDTH(2)) u_sat (
    .clock(clock), .reset(reset), .go(go), .finish(finish), .mode(mode),
    .data_in(data_in), .result(res[2]), .valid(val[2]), .busy(bsy[2]), .error(err[2]));

  int nvec = 0;
  int nerr = 0;

  // Reference model: protocol state plus the list of captured samples.
  int mst;          // 0 idle, 1 collecting, 2 done
  int mmode;
  int mvalid, mbusy, merr;
  int mres [3];
  int q [$];

  typedef struct {
    int go, fin, mode, data;
    int v, b, e;
    int r0, r1, r2;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sval(int i, int d);
    if (i == 1 && d >= 256) return d - 512;
    return d;
  endfunction

  function automatic int calc(int i, int m);
    int mx, mn, v, r, lim;
    mx = 0; mn = 0; r = 0;
    foreach (q[k]) begin
      v = sval(i, q[k]);
      if (k == 0) begin mx = v; mn = v; end
      else begin
        if (v > mx) mx = v;
        if (v < mn) mn = v;
      end
    end
    case (m)
      0: r = mx - mn;
      1: r = mx;
      2: r = mn;
      default: begin
`ifdef RANGE_TRACKER_MIDPOINT_EN
        r = (mx + mn) >>> 1;
`else
        lim = (i == 2) ? 3 : 255;
        r = (q.size() > lim) ? lim : q.size();
`endif
      end
    endcase
    return r & 32'h3FF;
  endfunction

  task automatic model_reset();
    mst = 0; mmode = 0; mvalid = 0; mbusy = 0; merr = 0;
    for (int i = 0; i < 3; i++) mres[i] = 0;
    q.delete();
  endtask

  task automatic model_step(int g, int f, int m, int d);
    if (mst != 1) begin
      if (g != 0) begin
        q.delete();
        q.push_back(d);
        mmode = m;
        merr = 0;
        if (f != 0) begin
          mst = 2; mvalid = 1; mbusy = 0;
          for (int i = 0; i < 3; i++) mres[i] = calc(i, mmode);
        end else begin
          mst = 1; mvalid = 0; mbusy = 1;
        end
      end else if (f != 0 && mst == 0) begin
        merr = 1;
      end
    end else begin
      if (g != 0) begin
        merr = 1; mst = 0; mbusy = 0; mvalid = 0;
        for (int i = 0; i < 3; i++) mres[i] = 0;
        q.delete();
      end else begin
        q.push_back(d);
        if (f != 0) begin
          mst = 2; mbusy = 0; mvalid = 1;
          for (int i = 0; i < 3; i++) mres[i] = calc(i, mmode);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic cyc(int g, int f, int m, int d);
    go = g[0]; finish = f[0]; mode = m[1:0]; data_in = d[8:0];
    @(posedge clock);
    #1;
    model_step(g, f, m, d);
  endtask

  task automatic chk_model(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), int'(val[i]), mvalid);
      chk($sformatf("%s_busy%0d", tag, i), int'(bsy[i]), mbusy);
      chk($sformatf("%s_error%0d", tag, i), int'(err[i]), merr);
      chk($sformatf("%s_result%0d", tag, i), int'(res[i]), mres[i]);
    end
  endtask

  task automatic chk_all(string tag, int v, int b, int e, int r0, int r1, int r2);
    int r [3];
    r[0] = r0; r[1] = r1; r[2] = r2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), int'(val[i]), v);
      chk($sformatf("%s_busy%0d", tag, i), int'(bsy[i]), b);
      chk($sformatf("%s_error%0d", tag, i), int'(err[i]), e);
      chk($sformatf("%s_result%0d", tag, i), int'(res[i]), r[i]);
    end
  endtask

  function automatic vec_t mk(int g, int f, int m, int d, int v, int b, int e,
                              int r0, int r1, int r2);
    vec_t t;
    t.go = g; t.fin = f; t.mode = m; t.data = d;
    t.v = v; t.b = b; t.e = e; t.r0 = r0; t.r1 = r1; t.r2 = r2;
    return t;
  endfunction

  initial begin
    int g, f, m, d, prev;

    // Unsigned range burst 5,300,17,42; signed view of 300 is -212.
    tbl.push_back(mk(1, 0, 0,   5, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 300, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0,  17, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 1, 0,  42, 1, 0, 0, 295, 254, 295));
    // Full-scale signed spread: -256 (9'h100) and 255, modes 00, 10, 01.
    tbl.push_back(mk(1, 0, 0, 256, 0, 1, 0, 295, 254, 295));
    tbl.push_back(mk(0, 1, 0, 255, 1, 0, 0,   1, 511,   1));
    tbl.push_back(mk(1, 0, 2, 256, 0, 1, 0,   1, 511,   1));
    tbl.push_back(mk(0, 1, 0, 255, 1, 0, 0, 255, 768, 255));
    tbl.push_back(mk(1, 0, 1, 256, 0, 1, 0, 255, 768, 255));
    tbl.push_back(mk(0, 1, 0, 255, 1, 0, 0, 256, 255, 256));
    // Single-sample capture, then finish alone in DONE is ignored.
    tbl.push_back(mk(1, 1, 1,   7, 1, 0, 0,   7,   7,   7));
    tbl.push_back(mk(0, 1, 0,  99, 1, 0, 0,   7,   7,   7));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 0,   7,   7,   7));
    // Constant stream gives range 0.
    tbl.push_back(mk(1, 0, 0,   9, 0, 1, 0,   7,   7,   7));
    tbl.push_back(mk(0, 0, 0,   9, 0, 1, 0,   7,   7,   7));
    tbl.push_back(mk(0, 1, 0,   9, 1, 0, 0,   0,   0,   0));
    // go mid-COLLECT, then finish in IDLE, then a legal go clears error.
    tbl.push_back(mk(1, 0, 0,   1, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(1, 0, 0,   2, 0, 0, 1,   0,   0,   0));
    tbl.push_back(mk(0, 1, 0,   3, 0, 0, 1,   0,   0,   0));
    tbl.push_back(mk(1, 0, 3,   1, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0,   2, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0,   3, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0,   4, 0, 1, 0,   0,   0,   0));
    tbl.push_back(mk(0, 0, 0,   5, 0, 1, 0,   0,   0,   0));
`ifdef RANGE_TRACKER_MIDPOINT_EN
    tbl.push_back(mk(0, 1, 0,   6, 1, 0, 0,   3,   3,   3));
    tbl.push_back(mk(1, 0, 3,  10, 0, 1, 0,   3,   3,   3));
    tbl.push_back(mk(0, 1, 0,   3, 1, 0, 0,   6,   6,   6));
`else
    tbl.push_back(mk(0, 1, 0,   6, 1, 0, 0,   6,   6,   3));
    tbl.push_back(mk(1, 0, 3,  10, 0, 1, 0,   6,   6,   3));
    tbl.push_back(mk(0, 1, 0,   3, 1, 0, 0,   2,   2,   2));
`endif

    reset = 1'b0; go = 1'b0; finish = 1'b0; mode = 2'b00; data_in = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].go, tbl[k].fin, tbl[k].mode, tbl[k].data);
      chk_all($sformatf("row%0d", k), tbl[k].v, tbl[k].b, tbl[k].e,
              tbl[k].r0, tbl[k].r1, tbl[k].r2);
    end

    // Asynchronous reset between edges while collecting.
    cyc(1, 0, 0, 50);
    cyc(0, 0, 0, 60);
    chk_all("precollect", 0, 1, 0, mres[0], mres[1], mres[2]);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cyc(1, 1, 1, 4);
    chk_all("after_reset", 1, 0, 0, 4, 4, 4);

    // Randomized traffic against the model.
    prev = 0;
    for (int n = 0; n < 3000; n++) begin
      g = ($urandom_range(0, 9) == 0) ? 1 : 0;
      f = ($urandom_range(0, 5) == 0) ? 1 : 0;
      m = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: d = prev;
        1: begin
          case ($urandom_range(0, 3))
            0: d = 0;
            1: d = 255;
            2: d = 256;
            default: d = 511;
          endcase
        end
        default: d = $urandom_range(0, 511);
      endcase
      prev = d;
      cyc(g, f, m, d);
      chk_model($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
